// File: rtl/rst_seq_pkg.sv
// Shared types and default parameters for the reset sequencing controller.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam int DEF_N_DOM    = 4;
    localparam int DEF_HOLD_CYC = 8;
    localparam int DEF_GAP_CYC  = 4;

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchronizer: asynchronous assertion, deassertion after two clock edges.
module rst_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic rst_n_s_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_n_s_o = sync_q[1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Releases N_DOM reset domains in order 0..N_DOM-1 after a hold interval, spaced by a gap
// interval; a software request restarts the whole sequence.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int N_DOM    = DEF_N_DOM,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int GAP_CYC  = DEF_GAP_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_rst_req,
    output logic [N_DOM-1:0] rst_out_n,
    output logic             seq_busy,
    output logic             seq_done
);

    localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOM - 1);

    logic rst_n_s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_DOM-1:0] out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             release_en;

    rst_sync u_rst_sync (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .rst_n_s_o (rst_n_s)
    );

    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        out_d      = out_q;
        busy_d     = busy_q;
        done_d     = done_q;
        release_en = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) release_en = 1'b1;
                else                    cnt_d = cnt_q + CNT_W'(1);
            end
            ST_RELEASE: begin
                if (cnt_q == GAP_LAST) release_en = 1'b1;
                else                   cnt_d = cnt_q + CNT_W'(1);
            end
            ST_DONE: ;
            default: state_d = ST_HOLD;
        endcase

        // Releases only ever OR in a bit, so a released domain stays released until restart.
        if (release_en) begin
            out_d = out_q | (N_DOM'(1) << idx_q);
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = ST_RELEASE;
            end
        end

        // A request overrides everything: restart rather than queue.
        if (sw_rst_req) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            out_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end
    end

    assign rst_out_n = out_q;
    assign seq_busy  = busy_q;
    assign seq_done  = done_q;

endmodule
